easy_axi_ar_arb: RTL and testbench
==================================

# easy_axi_ar_arb

Round-robin arbiter that shares one downstream AXI read-address (AR) channel between `N_MST` upstream AR masters. It sits between a set of AR-issuing masters and a single slave port. Each accepted request passes through one output register stage. The winning master index is prepended to the ID so read responses can be routed back. Full throughput is one AR transfer per cycle.

## Interface

Parameters:
- `N_MST`, 4, number of upstream masters; legal range 2..8.
- `IDX_W`, 2, master-index width; must satisfy 2^`IDX_W` >= `N_MST`.
- `ID_W`, 4, upstream ARID width.
- `ADDR_W`, 16, ARADDR width.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `s_arvalid`  in  `N_MST`  per-master AR valid; bit i belongs to master i.
- `s_arready`  out  `N_MST`  per-master AR ready; combinational; at most one bit high.
- `s_arid`  in  `N_MST`*`ID_W`  per-master ARID; master i occupies bits [i*`ID_W` +: `ID_W`].
- `s_araddr`  in  `N_MST`*`ADDR_W`  per-master ARADDR; same packing as `s_arid`.
- `m_arvalid`  out  1  downstream AR valid; registered.
- `m_arready`  in  1  downstream AR ready.
- `m_arid`  out  `IDX_W`+`ID_W`  equals {winner index, winner ARID}; registered.
- `m_araddr`  out  `ADDR_W`  winner ARADDR; registered.

## Operation

- State:
  - one output slot: `m_arvalid`, `m_arid`, `m_araddr`.
  - round-robin pointer `ptr` (`IDX_W` bits), holding the highest-priority index for the next arbitration.
- Slot free condition `free` = ~`m_arvalid` | `m_arready`. This covers an empty slot and a slot being drained in the same cycle.
- Arbitration is combinational and runs every cycle:
  - The winner is the first i with `s_arvalid[i]`=1, searching `ptr`, `ptr`+1, … wrapping at `N_MST`, not at 2^`IDX_W`.
  - `s_arready[winner]` = `free`. All other `s_arready` bits are 0.
  - With no valid requester, all `s_arready` bits are 0.
- Accept (`free` and at least one requester) at the rising edge:
  - `m_arvalid` is set to 1.
  - `m_arid` is set to {winner, `s_arid[winner]`}.
  - `m_araddr` is set to `s_araddr[winner]`.
  - `ptr` is set to (winner+1) mod `N_MST`.
- Drain without accept (`m_arvalid` & `m_arready`, no requester): `m_arvalid` is cleared to 0. `m_arid` and `m_araddr` hold their last values.
- Drain and accept in the same cycle: the slot is reloaded with the new winner and `m_arvalid` stays 1. There is no bubble.
- Backpressure (`m_arvalid`=1, `m_arready`=0):
  - All `s_arready` bits are 0.
  - `m_arvalid`, `m_arid`, `m_araddr` and `ptr` hold.
  - Upstream masters hold their requests, per AXI rules.
- `ptr` changes only on accept. A lone requester is granted back-to-back every free cycle.
- No request is ever lost or duplicated. Each upstream handshake produces exactly one downstream handshake, in acceptance order.

## Timing

- Reset (async assert, synchronous release at the next edge):
  - `m_arvalid`=0, `m_arid`=0, `m_araddr`=0, `ptr`=0.
  - `s_arready` is therefore all 0 while the slot is empty only if no `s_arvalid` bit is set.
- After release, master 0 has highest priority.
- Latency: upstream handshake at edge k gives `m_arvalid`=1 visible after edge k. The earliest downstream handshake is at edge k+1.
- Throughput: one transfer per cycle while `m_arready`=1 and any `s_arvalid` is set.
- `s_arready` depends combinationally on `s_arvalid`, `m_arvalid`, `m_arready` and `ptr`. `m_*` outputs are pure register outputs with no combinational path from inputs.
- Reset asserted mid-operation: the slot content is discarded immediately and outputs return to their reset values asynchronously. An in-flight unaccepted request is dropped.

## Test plan

- **Reset:** hold `rst_n`=0 with random inputs.
  - Required: `m_arvalid`=0, `m_arid`=0, `m_araddr`=0.
  - After release with only `s_arvalid[2]`=1, `s_arid[2]`=4'h5, `s_araddr[2]`=16'h1234 and `m_arready`=1: the next cycle shows `m_arvalid`=1, `m_arid`=6'h25, `m_araddr`=16'h1234.
- **Fairness:** all four masters continuously valid, `m_arready`=1.
  - Required: downstream index sequence 0,1,2,3,0,1…
  - One grant per cycle and no idle cycles.
- **Backpressure:** all masters valid, `m_arready`=0 for 5 cycles, then 1.
  - Required: exactly one accept (master 0), all `s_arready`=0 for the 5 cycles, and `m_arid`/`m_araddr` stable.
  - Then master 1 is accepted in the same cycle as the drain, with `m_arvalid` staying 1.
- **Pointer skip and wrap:** only masters 1 and 3 valid, `m_arready`=1.
  - Required: grants 1,3,1,3.
  - Then drop master 3 and raise master 0: the next grant is master 0, since `ptr` wrapped to 0 after master 3.
- **Drain without accept:** a single request from master 0, then no requesters.
  - Required: `m_arvalid` goes 1 for one cycle, then 0.
  - `m_arid` and `m_araddr` keep the master-0 values.
- **Mid-operation reset:** assert `rst_n`=0 while `m_arvalid`=1 and `m_arready`=0.
  - Required: `m_arvalid` goes to 0 without waiting for a clock edge.
  - After release, arbitration restarts from master 0.

Source files
------------

// File: rtl/easy_axi_ar_arb.sv
// easy_axi_ar_arb
//   Round-robin arbiter sharing one downstream AXI AR channel among N_MST
//   upstream masters. The winning request is captured in a single output
//   register slot; the winner index is prepended to ARID so read responses
//   can be routed back. Sustains one AR transfer per cycle.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   s_arvalid/arready   per-master AR handshake (bit i = master i)
//   s_arid, s_araddr    per-master ARID / ARADDR, master i at [i*W +: W]
//   m_arvalid/arready   downstream AR handshake (m_arvalid registered)
//   m_arid              {winner index, winner ARID}, registered
//   m_araddr            winner ARADDR, registered
module easy_axi_ar_arb #(
    parameter int N_MST  = 4,
    parameter int IDX_W  = 2,
    parameter int ID_W   = 4,
    parameter int ADDR_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_MST-1:0]          s_arvalid,
    output logic [N_MST-1:0]          s_arready,
    input  logic [N_MST*ID_W-1:0]     s_arid,
    input  logic [N_MST*ADDR_W-1:0]   s_araddr,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    output logic [IDX_W+ID_W-1:0]     m_arid,
    output logic [ADDR_W-1:0]         m_araddr
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] ptr_nxt;
    logic             any;
    logic             free;

    // Slot can take a new request when empty or being drained this cycle.
    assign free = ~m_arvalid | m_arready;

    // Search ptr, ptr+1, ... wrapping at N_MST (not 2^IDX_W); first valid wins.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cidx;
        win = '0;
        any = 1'b0;
        for (int k = 0; k < N_MST; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N_MST) cand = cand - N_MST;
            cidx = cand[IDX_W-1:0];
            if (!any && s_arvalid[cidx]) begin
                any = 1'b1;
                win = cidx;
            end
        end
    end

    always_comb begin
        s_arready = '0;
        if (any && free) s_arready[win] = 1'b1;
    end

    assign ptr_nxt = (win == IDX_W'(N_MST - 1)) ? '0 : win + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_arvalid <= 1'b0;
            m_arid    <= '0;
            m_araddr  <= '0;
            ptr       <= '0;
        end else if (free) begin
            if (any) begin
                // Accept (possibly while draining): reload slot, no bubble.
                m_arvalid <= 1'b1;
                m_arid    <= {win, s_arid[win*ID_W +: ID_W]};
                m_araddr  <= s_araddr[win*ADDR_W +: ADDR_W];
                ptr       <= ptr_nxt;
            end else begin
                // Drain with nothing to replace it; payload holds.
                m_arvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_easy_axi_ar_arb.sv
module tb_easy_axi_ar_arb;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int DW = 4;
    localparam int AW = 16;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] id;
        logic [AW-1:0] addr;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      s_arvalid = '0;
    logic [N-1:0]      s_arready;
    logic [N*DW-1:0]   s_arid = '0;
    logic [N*AW-1:0]   s_araddr = '0;
    logic              m_arvalid;
    logic              m_arready = 1'b0;
    logic [IW+DW-1:0]  m_arid;
    logic [AW-1:0]     m_araddr;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    logic          mvld = 1'b0;
    logic [IW-1:0] mptr = '0;
    ent_t          sb[$];

    easy_axi_ar_arb #(.N_MST(N), .IDX_W(IW), .ID_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_arid(s_arid), .s_araddr(s_araddr),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_arid(m_arid), .m_araddr(m_araddr)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: at each falling edge predict the grant, push the
    // accepted request, and pop/compare on each downstream handshake.
    always @(negedge clk) begin
        logic          found;
        logic [IW-1:0] w;
        logic [N-1:0]  erdy;
        logic          mfree;
        ent_t          e;
        if (!rst_n) begin
            mvld <= 1'b0;
            mptr <= '0;
            sb.delete();
        end else begin
            n_chk++;
            if (m_arvalid !== mvld) begin
                n_fail++;
                $display("FAIL m_arvalid: got %b expected %b at %0t", m_arvalid, mvld, $time);
            end
            mfree = !mvld || m_arready;
            found = 1'b0;
            w = '0;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (int'(mptr) + k) % N;
                if (!found && s_arvalid[c]) begin
                    found = 1'b1;
                    w = IW'(c);
                end
            end
            erdy = '0;
            if (found && mfree) erdy[w] = 1'b1;
            n_chk++;
            if (s_arready !== erdy) begin
                n_fail++;
                $display("FAIL s_arready: got %b expected %b at %0t", s_arready, erdy, $time);
            end
            if (mvld && m_arready) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_underflow: got handshake expected none at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    if ({m_arid, m_araddr} !== e) begin
                        n_fail++;
                        $display("FAIL sb_data: got id=%h addr=%h expected id=%h addr=%h at %0t",
                                 m_arid, m_araddr, {e.idx, e.id}, e.addr, $time);
                    end
                end
            end
            if (mfree) begin
                if (found) begin
                    sb.push_back('{idx: w, id: s_arid[w*DW +: DW], addr: s_araddr[w*AW +: AW]});
                    mvld <= 1'b1;
                    mptr <= (int'(w) == N - 1) ? '0 : w + 1'b1;
                end else begin
                    mvld <= 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) begin
            s_arid[i*DW +: DW]   = DW'($urandom);
            s_araddr[i*AW +: AW] = AW'($urandom);
        end
    endtask

    // Reset with inputs idle; returns just after a rising edge, reset released.
    task automatic apply_reset();
        s_arvalid = '0;
        m_arready = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_idx(input string nm, input logic [IW-1:0] exp);
        n_chk++;
        if (m_arvalid !== 1'b1 || m_arid[IW+DW-1 -: IW] !== exp) begin
            n_fail++;
            $display("FAIL %s: got vld=%b idx=%0d expected vld=1 idx=%0d", nm, m_arvalid,
                     m_arid[IW+DW-1 -: IW], exp);
        end
    endtask

    task automatic test_reset();
        tick();
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            s_arvalid = N'($urandom);
            m_arready = 1'($urandom);
            rand_data();
            tick();
            n_chk++;
            if (m_arvalid !== 1'b0 || m_arid !== '0 || m_araddr !== '0) begin
                n_fail++;
                $display("FAIL reset_state: got vld=%b id=%h addr=%h expected 0/0/0",
                         m_arvalid, m_arid, m_araddr);
            end
        end
        s_arvalid = 4'b0100;
        s_arid[2*DW +: DW]   = 4'h5;
        s_araddr[2*AW +: AW] = 16'h1234;
        m_arready = 1'b1;
        rst_n = 1'b1;
        tick();
        s_arvalid = '0;
        n_chk++;
        if (m_arvalid !== 1'b1 || m_arid !== 6'h25 || m_araddr !== 16'h1234) begin
            n_fail++;
            $display("FAIL reset_first: got vld=%b id=%h addr=%h expected 1/25/1234",
                     m_arvalid, m_arid, m_araddr);
        end
        tick();
    endtask

    task automatic test_fairness();
        apply_reset();
        rand_data();
        s_arvalid = '1;
        m_arready = 1'b1;
        for (int j = 0; j < 12; j++) begin
            tick();
            chk_idx("fairness", IW'(j % N));
        end
        s_arvalid = '0;
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        logic [IW+DW-1:0] id0;
        logic [AW-1:0]    ad0;
        apply_reset();
        rand_data();
        s_arvalid = '1;
        m_arready = 1'b0;
        tick();
        chk_idx("bp_first", 2'd0);
        id0 = {2'd0, s_arid[0 +: DW]};
        ad0 = s_araddr[0 +: AW];
        for (int j = 0; j < 5; j++) begin
            tick();
            n_chk++;
            if (s_arready !== '0 || m_arvalid !== 1'b1 || m_arid !== id0 || m_araddr !== ad0) begin
                n_fail++;
                $display("FAIL bp_hold: got rdy=%b vld=%b id=%h addr=%h expected 0000/1/%h/%h",
                         s_arready, m_arvalid, m_arid, m_araddr, id0, ad0);
            end
        end
        m_arready = 1'b1;
        #1;
        n_chk++;
        if (s_arready !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_release_rdy: got %b expected 0010", s_arready);
        end
        tick();
        s_arvalid = '0;
        chk_idx("bp_reload", 2'd1);
        tick();
        tick();
    endtask

    task automatic test_skip_wrap();
        logic [IW-1:0] exp [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
        apply_reset();
        rand_data();
        s_arvalid = 4'b1010;
        m_arready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk_idx("skip", exp[j]);
        end
        s_arvalid = 4'b0011;
        tick();
        chk_idx("wrap", 2'd0);
        s_arvalid = '0;
        tick();
        tick();
    endtask

    task automatic test_drain();
        logic [IW+DW-1:0] id0;
        logic [AW-1:0]    ad0;
        apply_reset();
        rand_data();
        id0 = {2'd0, s_arid[0 +: DW]};
        ad0 = s_araddr[0 +: AW];
        s_arvalid = 4'b0001;
        m_arready = 1'b1;
        tick();
        s_arvalid = '0;
        chk_idx("drain_load", 2'd0);
        tick();
        n_chk++;
        if (m_arvalid !== 1'b0 || m_arid !== id0 || m_araddr !== ad0) begin
            n_fail++;
            $display("FAIL drain_hold: got vld=%b id=%h addr=%h expected 0/%h/%h",
                     m_arvalid, m_arid, m_araddr, id0, ad0);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        apply_reset();
        rand_data();
        s_arvalid = '1;
        m_arready = 1'b0;
        tick();
        tick();
        chk_idx("mid_loaded", 2'd0);
        #1;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (m_arvalid !== 1'b0 || m_arid !== '0 || m_araddr !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_async: got vld=%b id=%h addr=%h expected 0/0/0",
                     m_arvalid, m_arid, m_araddr);
        end
        tick();
        tick();
        m_arready = 1'b1;
        rst_n = 1'b1;
        tick();
        chk_idx("mid_restart", 2'd0);
        s_arvalid = '0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_backpressure();
        test_skip_wrap();
        test_drain();
        test_mid_reset();
        tick();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_empty: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
